alu_seq: RTL and testbench

Parametrised, handshaked integer ALU for the RISC-V execute stage. Adds a registered output, valid/ready flow control and iterative RV32M-style multiply/divide to the base combinational op set. Single-cycle ops complete in one cycle; multiply/divide take WIDTH cycles. Sits between the decode/operand-read stage and writeback, stalling the pipeline via `in_ready`.

---
 rtl/alu_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_seq                                                      |
// | Description : Handshaked integer ALU for the execute stage. Single-cycle   |
// |               ops (add/sub/shift/compare/logic) register their result one  |
// |               cycle after acceptance. MUL/MULHU/DIVU/REMU iterate one bit  |
// |               per cycle for WIDTH cycles (shift-add / restoring divide).   |
// | Ports       : clk, rst_n (async active-low), flush (sync abort)            |
// |               in_valid/in_ready, in_a, in_b, op_code  -- operation input   |
// |               out_valid/out_ready, out_result         -- registered result |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int c_log2w = $clog2(WIDTH);

    localparam logic [3:0] c_op_add   = 4'b0000;
    localparam logic [3:0] c_op_sub   = 4'b0001;
    localparam logic [3:0] c_op_sll   = 4'b0010;
    localparam logic [3:0] c_op_sltu  = 4'b0011;
    localparam logic [3:0] c_op_xor   = 4'b0100;
    localparam logic [3:0] c_op_srl   = 4'b0101;
    localparam logic [3:0] c_op_slt   = 4'b0110;
    localparam logic [3:0] c_op_sra   = 4'b0111;
    localparam logic [3:0] c_op_or    = 4'b1000;
    localparam logic [3:0] c_op_and   = 4'b1001;
    localparam logic [3:0] c_op_mul   = 4'b1010;
    localparam logic [3:0] c_op_remu  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Iterative datapath registers.
    //   multiply: r_m = multiplicand, r_acc = high product half, r_q = multiplier / low half
    //   divide  : r_m = divisor,      r_acc = partial remainder, r_q = dividend / quotient
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_acc;
    logic [c_log2w-1:0] r_cnt;
    logic               r_is_div;
    logic               r_sel_lo;
    logic [WIDTH-1:0]   r_result;

    logic               w_iter;
    logic               w_accept;
    logic               w_last;
    logic [c_log2w-1:0] w_shamt;
    logic signed [WIDTH-1:0] w_a_signed;
    logic [WIDTH-1:0]   w_alu;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;

    assign w_iter     = (op_code >= c_op_mul) && (op_code <= c_op_remu);
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_last     = (r_cnt == c_log2w'(WIDTH - 1));
    assign w_shamt    = in_b[c_log2w-1:0];
    assign w_a_signed = $signed(in_a);
    assign out_result = r_result;

    // ------------------------------------------------------------------
    // Single-cycle operations
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = '0;
        case (op_code)
            c_op_add:  w_alu = in_a + in_b;
            c_op_sub:  w_alu = in_a - in_b;
            c_op_sll:  w_alu = in_a << w_shamt;
            c_op_sltu: w_alu = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            c_op_xor:  w_alu = in_a ^ in_b;
            c_op_srl:  w_alu = in_a >> w_shamt;
            c_op_slt:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            c_op_sra:  w_alu = w_a_signed >>> w_shamt;
            c_op_or:   w_alu = in_a | in_b;
            c_op_and:  w_alu = in_a & in_b;
            default:   w_alu = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    // Shift-add: conditionally add the multiplicand into the high half, then
    // shift {carry, high, low} right by one. After WIDTH steps {r_acc, r_q}
    // holds the full 2*WIDTH product.
    assign w_sum    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // Restoring divide: bring the next dividend bit into the remainder and
    // subtract the divisor when it fits. A zero divisor always "fits", which
    // naturally yields an all-ones quotient and the dividend as remainder.
    assign w_rem_sh = {r_acc, r_q[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_m});
    // When w_ge holds the true difference is below the divisor, so the low
    // WIDTH bits are exact.
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_m;

    always_comb begin
        w_acc_nxt = '0;
        w_q_nxt   = '0;
        if (r_is_div) begin
            w_acc_nxt = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
        end else begin
            w_acc_nxt = w_sum[WIDTH:1];
            w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_iter ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_nxt = w_iter ? S_BUSY : S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort wins over everything, including a same-cycle acceptance.
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m      <= '0;
            r_q      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sel_lo <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            if (w_iter) begin
                // op_code[2] separates DIVU/REMU from MUL/MULHU; op_code[0]
                // picks the upper product half or the remainder.
                r_m      <= op_code[2] ? in_b : in_a;
                r_q      <= op_code[2] ? in_a : in_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_is_div <= op_code[2];
                r_sel_lo <= ~op_code[0];
            end else begin
                r_result <= w_alu;
            end
        end else if (r_state == S_BUSY) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= r_sel_lo ? w_q_nxt : w_acc_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_seq                                                   |
// | Description : Self-checking bench for alu_seq: fixed vector table, hand-   |
// |               written handshake/flush/reset sequences and random ops       |
// |               checked against a behavioural reference model.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   op_code;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .op_code    (op_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the operation definitions.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        int sh;
        sh = int'(b[4:0]);
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a << sh;
            4'h3: return (a < b) ? 32'd1 : 32'd0;
            4'h4: return a ^ b;
            4'h5: return a >> sh;
            4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: return $signed(a) >>> sh;
            4'h8: return a | b;
            4'h9: return a & b;
            4'hA: return p[W-1:0];
            4'hB: return p[2*W-1:W];
            4'hC: return (b == 0) ? {W{1'b1}} : a / b;
            4'hD: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    // Issue one op with out_ready=1, wait for its result, check value,
    // latency and that in_ready stays low while iterating. Operands are
    // scrambled after acceptance.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string name);
        int lat;
        int busy_rdy;
        bit iter;
        iter = (op >= 4'hA) && (op <= 4'hD);
        out_ready = 1'b1;
        #1;
        check({name, "_ready"}, {31'b0, in_ready}, 32'd1);
        op_code  = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        lat      = 0;
        busy_rdy = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            in_a     = $urandom;
            in_b     = $urandom;
            op_code  = 4'($urandom);
            lat++;
            if (!out_valid && in_ready) busy_rdy++;
        end while (!out_valid && lat < 100);
        check({name, "_result"}, out_result, exp);
        check({name, "_latency"}, lat, iter ? W + 1 : 1);
        if (iter) check({name, "_busy_in_ready"}, busy_rdy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [W-1:0] ba [5];
        logic [W-1:0] bb [5];
        logic [3:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        op_code   = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result",    out_result,         32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- vector table ----------------
        vecs[0]  = '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[1]  = '{4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[2]  = '{4'h7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
        vecs[3]  = '{4'h5, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
        vecs[4]  = '{4'h6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[5]  = '{4'h3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[6]  = '{4'h2, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006};
        vecs[7]  = '{4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        vecs[8]  = '{4'h8, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
        vecs[9]  = '{4'h9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[10] = '{4'hE, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000};
        vecs[11] = '{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{4'hA, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        vecs[13] = '{4'hB, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
        vecs[14] = '{4'hC, 32'd100,       32'd7,         32'd14};
        vecs[15] = '{4'hD, 32'd100,       32'd7,         32'd2};
        vecs[16] = '{4'hC, 32'd7,         32'd0,         32'hFFFF_FFFF};
        vecs[17] = '{4'hD, 32'd7,         32'd0,         32'd7};
        vecs[18] = '{4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[19] = '{4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[20] = '{4'h3, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[21] = '{4'h6, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[22] = '{4'h7, 32'h7FFF_FFF0, 32'h0000_0003, 32'h0FFF_FFFE};
        vecs[23] = '{4'hD, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F};

        for (int i = 0; i < 24; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end
        in_valid = 1'b0;
        @(negedge clk);

        // ---------------- back-to-back ADDs, then a 5-cycle stall ----------------
        for (int k = 0; k < 5; k++) begin
            ba[k] = 32'h1111_1111 * (k + 1);
            bb[k] = 32'hF000_0000 + k;
        end
        out_ready = 1'b1;
        op_code   = 4'h0;
        in_a      = ba[0];
        in_b      = bb[0];
        in_valid  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("b2b_valid",  {31'b0, out_valid}, 32'd1);
            check("b2b_result", out_result, ba[k-1] + bb[k-1]);
            in_a = ba[k];
            in_b = bb[k];
        end
        @(negedge clk);
        check("b2b_last_result", out_result, ba[3] + bb[3]);
        out_ready = 1'b0;
        in_a      = ba[4];
        in_b      = bb[4];
        #1;
        check("stall_in_ready_now", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid",    {31'b0, out_valid}, 32'd1);
            check("stall_result",   out_result, ba[3] + bb[3]);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        check("release_valid",  {31'b0, out_valid}, 32'd1);
        check("release_result", out_result, ba[4] + bb[4]);
        in_valid = 1'b0;
        @(negedge clk);
        check("drain_valid", {31'b0, out_valid}, 32'd0);

        // ---------------- flush 10 cycles into a DIVU ----------------
        op_code  = 4'hC;
        in_a     = 32'd100;
        in_b     = 32'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        op_code  = 4'h0;
        in_a     = 32'd1;
        in_b     = 32'd2;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_busy_valid",    {31'b0, out_valid}, 32'd0);
        check("flush_busy_in_ready", {31'b0, in_ready},  32'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("flush_busy_no_result", cnt, 0);

        // ---------------- flush while a result is held ----------------
        out_ready = 1'b0;
        op_code   = 4'h0;
        in_a      = 32'd3;
        in_b      = 32'd4;
        in_valid  = 1'b1;
        @(negedge clk);
        check("held_valid",  {31'b0, out_valid}, 32'd1);
        check("held_result", out_result, 32'd7);
        // A new op offered with the flush must be dropped.
        flush     = 1'b1;
        out_ready = 1'b1;
        in_a      = 32'd9;
        in_b      = 32'd9;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_done_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("flush_done_still_idle", {31'b0, out_valid}, 32'd0);

        // ---------------- reset mid-MUL ----------------
        do_op(4'h0, 32'd5, 32'd6, 32'd11, "pre_rst_add");
        op_code  = 4'hA;
        in_a     = 32'h0001_2345;
        in_b     = 32'h0000_6789;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid",    {31'b0, out_valid}, 32'd0);
        check("rst_mid_result",   out_result, 32'd0);
        check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rst_mid_no_result", cnt, 0);
        do_op(4'h1, 32'd10, 32'd3, 32'd7, "post_rst_sub");

        // ---------------- random ops vs reference model ----------------
        for (int n = 0; n < 300; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, ref_alu(rop, ra, rb), $sformatf("rand%0d_op%0h", n, rop));
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
